muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have no parameters; operand width is fixed at 32.
REQ-002 cclk  in  1  sole clock, all state changes on rising edge.
REQ-003 rstb  in  1  reset, synchronous, active-low.
REQ-004 start  in  1  request; sampled only in IDLE.
REQ-005 op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a, b  in  32 each  operands (rs, rt), captured on accepted start.
REQ-007 abort  in  1  exception flush; cancels operation in progress.
REQ-008 hi_we, lo_we  in  1 each  MTHI/MTLO write strobes.
REQ-009 wdata  in  32  MTHI/MTLO data.
REQ-010 busy  out  1  high in PREP, ITER, FIXUP.
REQ-011 done  out  1  one-cycle pulse, state DONE.
REQ-012 hi, lo  out  32 each  registered HI/LO.
REQ-013 dbz  out  1  divide-by-zero flag.
REQ-014 illegal_op  out  1  one-cycle pulse, disabled op requested.

Function
REQ-015 SHALL implement FSM IDLE->PREP->ITER->FIXUP->DONE->IDLE.
REQ-016 IDLE & start SHALL capture a, b, op and enter PREP; start outside IDLE ignored.
REQ-017 PREP SHALL take absolute values for signed ops, record result signs, load counter = 31.
REQ-018 ITER SHALL perform one radix-2 step per cycle (shift-add multiply / restoring shift-subtract divide), 32 steps; counter 0 -> FIXUP.
REQ-019 FIXUP SHALL negate: product if sign(a)^sign(b); quotient if sign(a)^sign(b); remainder if sign(a).
REQ-020 hi/lo SHALL update on FIXUP->DONE edge: MULT* hi=product[63:32], lo=product[31:0]; DIV* lo=quotient, hi=remainder.
REQ-021 Latency: start sampled at edge 0, done high after edge 34 for exactly one cycle, busy high after edges 0..33.
REQ-022 DIV/DIVU with b=0: lo=32'hFFFFFFFF, hi=a, dbz=1; dbz clears on next accepted start.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no flag.
REQ-024 abort while busy SHALL return to IDLE next edge, hi/lo unchanged, no done; abort in IDLE/DONE no effect.
REQ-025 hi_we/lo_we SHALL write wdata only when busy=0 and start not accepted same cycle; ignored otherwise.
REQ-026 Write in DONE cycle SHALL overwrite the just-written result.
REQ-027 start and abort same cycle in IDLE: start accepted.

Reset
REQ-028 rstb=0 at edge SHALL force IDLE, hi=lo=0, busy=done=dbz=illegal_op=0, counter=0, regardless of state.
REQ-029 Reset mid-operation SHALL discard operation; no done pulse.

Configuration
REQ-030 Macro MULDIV_DIV_EN: defined -> DIV/DIVU supported per REQ-018..023.
REQ-031 Undefined -> divide datapath omitted; start with op[1]=1 in IDLE SHALL stay IDLE, pulse illegal_op one cycle, leave hi/lo/dbz unchanged; dbz tied 0.

Structure
REQ-032 Shared package muldiv_pkg SHALL hold op encodings, FSM state encodings, iteration count (32).
REQ-033 Single sub-module muldiv_step SHALL hold combinational one-iteration add/subtract-shift logic; FSM, counter, registers stay in muldiv_ctrl.

Verification
REQ-034 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001, done after edge 34.
REQ-035 MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB.
REQ-036 DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
REQ-037 DIVU a=100 b=0 -> lo=0xFFFFFFFF hi=100 dbz=1; next MULTU start clears dbz.
REQ-038 hi=0x11, lo=0x22; MULTU 5x6, abort at edge 10 -> hi=0x11 lo=0x22, busy=0 after edge 11, no done; hi_we during busy ignored.
REQ-039 rstb=0 at edge 20 of DIV -> hi=lo=0, IDLE; without MULDIV_DIV_EN, DIV start -> illegal_op pulse, busy stays 0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide controller: operation
// encodings, FSM state encodings, iteration count and small helpers.
package muldiv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned ITER_COUNT = 32;
    localparam int unsigned CNT_W      = 5;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITER_COUNT - 1);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREP  = 3'd1,
        ST_ITER  = 3'd2,
        ST_FIXUP = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Magnitude of a 32-bit operand; unsigned operands pass through.
    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        logic [31:0] r;
        if (is_signed && v[31]) begin
            r = 32'd0 - v;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the pipeline and the multiply/divide unit.
interface muldiv_if;
    import muldiv_pkg::*;

    logic        start;
    op_e         op;
    logic [31:0] a;
    logic [31:0] b;
    logic        abort;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    logic        illegal_op;

    modport master (
        output start, op, a, b, abort, hi_we, lo_we, wdata,
        input  busy, done, hi, lo, dbz, illegal_op
    );

    modport slave (
        input  start, op, a, b, abort, hi_we, lo_we, wdata,
        output busy, done, hi, lo, dbz, illegal_op
    );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract
// for divide. The divide half exists only when MULDIV_DIV_EN is defined.
module muldiv_step (
`ifdef MULDIV_DIV_EN
    input  logic        is_div,
`endif
    input  logic [31:0] acc_hi,
    input  logic [31:0] acc_lo,
    input  logic [31:0] opnd,
    output logic [31:0] acc_hi_nx,
    output logic [31:0] acc_lo_nx
);

    logic [32:0] sum_s;
`ifdef MULDIV_DIV_EN
    logic [32:0] shl_s;
    logic        ge_s;
`endif

    // Next accumulator value for the selected iteration type
    always_comb begin
        sum_s     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);
        acc_hi_nx = sum_s[32:1];
        acc_lo_nx = {sum_s[0], acc_lo[31:1]};
`ifdef MULDIV_DIV_EN
        // Partial remainder is always below the divisor, so the shifted
        // value fits 33 bits and the difference fits 32 bits.
        shl_s = {acc_hi, acc_lo[31]};
        ge_s  = (shl_s >= {1'b0, opnd});
        if (is_div) begin
            if (ge_s) begin
                acc_hi_nx = shl_s[31:0] - opnd;
                acc_lo_nx = {acc_lo[30:0], 1'b1};
            end else begin
                acc_hi_nx = shl_s[31:0];
                acc_lo_nx = {acc_lo[30:0], 1'b0};
            end
        end else begin
            acc_hi_nx = sum_s[32:1];
            acc_lo_nx = {sum_s[0], acc_lo[31:1]};
        end
`endif
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative 32x32 multiply/divide controller with HI/LO result registers.
// Divide support is built only when MULDIV_DIV_EN is defined; otherwise a
// divide request raises illegal_op and leaves all state untouched.
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic     cclk,
    input  logic     rstb,
    muldiv_if.slave  bus
);

    state_e          state_r, state_nx;
    logic [CNT_W-1:0] cnt_r;
    op_e             op_r;
    logic [31:0]     a_r, b_r;
    logic [31:0]     acc_hi_r, acc_lo_r, opnd_r;
    logic [31:0]     step_hi_s, step_lo_s;
    logic            neg_q_r;
`ifdef MULDIV_DIV_EN
    logic            neg_r_r;
    logic            dbz_r;
`endif
    logic [31:0]     hi_r, lo_r;
    logic            busy_r, done_r, illegal_r;
    logic            op_legal_s, accept_s, illegal_s, commit_s, wr_ok_s;
    logic            is_div_s, is_signed_s, pr_signed_s;
    logic [63:0]     prod_s;
    logic [31:0]     res_hi_s, res_lo_s;

    assign is_div_s    = op_r[1];
    assign is_signed_s = ~op_r[0];
`ifdef MULDIV_DIV_EN
    assign op_legal_s  = 1'b1;
`else
    assign op_legal_s  = ~bus.op[1];
`endif
    assign pr_signed_s = is_signed_s;
    assign accept_s  = (state_r == ST_IDLE) && bus.start && op_legal_s;
    assign illegal_s = (state_r == ST_IDLE) && bus.start && !op_legal_s;
    assign commit_s  = (state_r == ST_FIXUP) && !bus.abort;
    assign wr_ok_s   = !busy_r && !accept_s;
    assign prod_s    = {acc_hi_r, acc_lo_r};

    muldiv_step u_step (
`ifdef MULDIV_DIV_EN
        .is_div    (is_div_s),
`endif
        .acc_hi    (acc_hi_r),
        .acc_lo    (acc_lo_r),
        .opnd      (opnd_r),
        .acc_hi_nx (step_hi_s),
        .acc_lo_nx (step_lo_s)
    );

    // Next-state logic; abort pulls any busy state back to IDLE
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE:  if (accept_s)   state_nx = ST_PREP;  else state_nx = ST_IDLE;
            ST_PREP:  if (bus.abort)  state_nx = ST_IDLE;  else state_nx = ST_ITER;
            ST_ITER: begin
                if (bus.abort)               state_nx = ST_IDLE;
                else if (cnt_r == 5'd0)      state_nx = ST_FIXUP;
                else                         state_nx = ST_ITER;
            end
            ST_FIXUP: if (bus.abort)  state_nx = ST_IDLE;  else state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Sign correction of the raw magnitudes, plus the divide-by-zero result
    always_comb begin
        res_hi_s = acc_hi_r;
        res_lo_s = acc_lo_r;
        if (is_div_s) begin
`ifdef MULDIV_DIV_EN
            if (b_r == 32'd0) begin
                res_hi_s = a_r;
                res_lo_s = 32'hFFFF_FFFF;
            end else begin
                res_lo_s = neg_q_r ? (32'd0 - acc_lo_r) : acc_lo_r;
                res_hi_s = neg_r_r ? (32'd0 - acc_hi_r) : acc_hi_r;
            end
`else
            res_hi_s = acc_hi_r;
            res_lo_s = acc_lo_r;
`endif
        end else begin
            if (neg_q_r) begin
                {res_hi_s, res_lo_s} = 64'd0 - prod_s;
            end else begin
                {res_hi_s, res_lo_s} = prod_s;
            end
        end
    end

    // FSM state, iteration counter, captured operands and accumulator
    always_ff @(posedge cclk) begin
        if (!rstb) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 5'd0;
            op_r     <= OP_MULT;
            a_r      <= 32'd0;
            b_r      <= 32'd0;
            acc_hi_r <= 32'd0;
            acc_lo_r <= 32'd0;
            opnd_r   <= 32'd0;
            neg_q_r  <= 1'b0;
`ifdef MULDIV_DIV_EN
            neg_r_r  <= 1'b0;
`endif
        end else begin
            state_r <= state_nx;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r <= bus.op;
                        a_r  <= bus.a;
                        b_r  <= bus.b;
                    end
                end
                ST_PREP: begin
                    acc_hi_r <= 32'd0;
                    acc_lo_r <= abs32(a_r, pr_signed_s);
                    opnd_r   <= abs32(b_r, pr_signed_s);
                    neg_q_r  <= pr_signed_s & (a_r[31] ^ b_r[31]);
`ifdef MULDIV_DIV_EN
                    neg_r_r  <= pr_signed_s & a_r[31];
`endif
                    cnt_r    <= CNT_LOAD;
                end
                ST_ITER: begin
                    acc_hi_r <= step_hi_s;
                    acc_lo_r <= step_lo_s;
                    if (cnt_r != 5'd0) begin
                        cnt_r <= cnt_r - 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered status outputs and the HI/LO architectural registers
    always_ff @(posedge cclk) begin
        if (!rstb) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            illegal_r <= 1'b0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
`ifdef MULDIV_DIV_EN
            dbz_r     <= 1'b0;
`endif
        end else begin
            busy_r    <= (state_nx == ST_PREP) || (state_nx == ST_ITER) || (state_nx == ST_FIXUP);
            done_r    <= (state_nx == ST_DONE);
            illegal_r <= illegal_s;
`ifdef MULDIV_DIV_EN
            if (accept_s) begin
                dbz_r <= 1'b0;
            end else if (commit_s && is_div_s && (b_r == 32'd0)) begin
                dbz_r <= 1'b1;
            end
`endif
            if (commit_s) begin
                hi_r <= res_hi_s;
                lo_r <= res_lo_s;
            end else begin
                if (wr_ok_s && bus.hi_we) hi_r <= bus.wdata;
                if (wr_ok_s && bus.lo_we) lo_r <= bus.wdata;
            end
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.hi         = hi_r;
    assign bus.lo         = lo_r;
    assign bus.illegal_op = illegal_r;
`ifdef MULDIV_DIV_EN
    assign bus.dbz        = dbz_r;
`else
    assign bus.dbz        = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl. Divide vectors are applied
// when MULDIV_DIV_EN is defined; otherwise the illegal-op path is exercised.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic cclk;
    logic rstb;
    int   vecs;
    int   errs;
    logic dbz_at_start;
    logic done_seen;

    muldiv_if bus ();

    muldiv_ctrl dut (
        .cclk (cclk),
        .rstb (rstb),
        .bus  (bus)
    );

    initial cclk = 1'b0;
    always #5 cclk = ~cclk;

    task automatic tick();
        @(posedge cclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation and follow it to the DONE cycle, checking latency.
    task automatic run_op(input op_e op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic lat_ok;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        tick();
        bus.start    = 1'b0;
        dbz_at_start = bus.dbz;
        check({tag, "_busy_e0"}, 64'(bus.busy), 64'd1);
        lat_ok = 1'b1;
        for (int i = 1; i <= 33; i++) begin
            tick();
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) lat_ok = 1'b0;
        end
        check({tag, "_busy_e1_33"}, 64'(lat_ok), 64'd1);
        tick();
        check({tag, "_busy_done_e34"}, 64'({bus.busy, bus.done}), 64'd1);
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        rstb = 1'b0;
        bus.start = 1'b0;
        bus.op    = OP_MULTU;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        bus.abort = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = 32'd0;

        tick();
        tick();
        tick();
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        check("rst_flags", 64'({bus.busy, bus.done, bus.dbz, bus.illegal_op}), 64'd0);
        rstb = 1'b1;
        tick();

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        check("multu_max_hi", 64'(bus.hi), 64'hFFFF_FFFE);
        check("multu_max_lo", 64'(bus.lo), 64'h0000_0001);
        tick();
        check("multu_max_done_e35", 64'(bus.done), 64'd0);

        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, "mult_neg");
        check("mult_neg_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        check("mult_neg_lo", 64'(bus.lo), 64'hFFFF_FFEB);
        tick();

        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, "mult_min");
        check("mult_min_hi", 64'(bus.hi), 64'h4000_0000);
        check("mult_min_lo", 64'(bus.lo), 64'h0000_0000);
        tick();

        run_op(OP_MULTU, 32'h1234_5678, 32'h0000_0010, "multu_shift");
        check("multu_shift_hi", 64'(bus.hi), 64'h0000_0001);
        check("multu_shift_lo", 64'(bus.lo), 64'h2345_6780);
        tick();

        // MTHI / MTLO while idle
        bus.hi_we = 1'b1;
        bus.wdata = 32'h11;
        tick();
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h22;
        tick();
        bus.lo_we = 1'b0;
        check("mthi", 64'(bus.hi), 64'h11);
        check("mtlo", 64'(bus.lo), 64'h22);

        // Abort mid-multiply; HI write while busy must be dropped
        bus.op    = OP_MULTU;
        bus.a     = 32'd5;
        bus.b     = 32'd6;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0000_DEAD;
        for (int i = 1; i <= 10; i++) tick();
        bus.hi_we = 1'b0;
        check("abort_busy_e10", 64'(bus.busy), 64'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_busy_e11", 64'(bus.busy), 64'd0);
        check("abort_hi", 64'(bus.hi), 64'h11);
        check("abort_lo", 64'(bus.lo), 64'h22);
        done_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) done_seen = 1'b1;
        end
        check("abort_no_done", 64'(done_seen), 64'd0);

        // Start and abort together in IDLE: start wins
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("start_abort_idle", 64'(bus.busy), 64'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_prep", 64'({bus.busy, bus.done}), 64'd0);
        check("abort_prep_hilo", {32'(bus.hi), 32'(bus.lo)}, {32'h11, 32'h22});

`ifdef MULDIV_DIV_EN
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg");
        check("div_neg_lo", 64'(bus.lo), 64'hFFFF_FFFD);
        check("div_neg_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        tick();

        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        check("div_ovf_lo", 64'(bus.lo), 64'h8000_0000);
        check("div_ovf_hi", 64'(bus.hi), 64'h0000_0000);
        check("div_ovf_dbz", 64'(bus.dbz), 64'd0);
        tick();

        run_op(OP_DIVU, 32'd100, 32'd7, "divu");
        check("divu_lo", 64'(bus.lo), 64'd14);
        check("divu_hi", 64'(bus.hi), 64'd2);
        tick();

        run_op(OP_DIVU, 32'd100, 32'd0, "divu_zero");
        check("divu_zero_lo", 64'(bus.lo), 64'hFFFF_FFFF);
        check("divu_zero_hi", 64'(bus.hi), 64'd100);
        check("divu_zero_dbz", 64'(bus.dbz), 64'd1);
        tick();
        check("dbz_sticky", 64'(bus.dbz), 64'd1);
`endif

        // Next accepted start clears dbz; write in DONE overwrites the result
        run_op(OP_MULTU, 32'd2, 32'd3, "multu_small");
        check("dbz_cleared", 64'(dbz_at_start), 64'd0);
        check("multu_small_hilo", {32'(bus.hi), 32'(bus.lo)}, {32'd0, 32'd6});
        bus.lo_we = 1'b1;
        bus.wdata = 32'h55;
        tick();
        bus.lo_we = 1'b0;
        check("done_write_lo", 64'(bus.lo), 64'h55);
        check("done_write_hi", 64'(bus.hi), 64'd0);

`ifndef MULDIV_DIV_EN
        bus.op    = OP_DIV;
        bus.a     = 32'd9;
        bus.b     = 32'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("illegal_pulse", 64'({bus.illegal_op, bus.busy}), 64'b10);
        tick();
        check("illegal_clear", 64'({bus.illegal_op, bus.busy, bus.done, bus.dbz}), 64'd0);
        check("illegal_hilo", {32'(bus.hi), 32'(bus.lo)}, {32'd0, 32'h55});
`endif

        // Reset in the middle of an operation
`ifdef MULDIV_DIV_EN
        bus.op = OP_DIV;
`else
        bus.op = OP_MULTU;
`endif
        bus.a     = 32'hFFFF_FFF9;
        bus.b     = 32'd2;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i <= 19; i++) tick();
        check("mid_rst_busy_e19", 64'(bus.busy), 64'd1);
        rstb = 1'b0;
        tick();
        rstb = 1'b1;
        check("mid_rst_hilo", {32'(bus.hi), 32'(bus.lo)}, 64'd0);
        check("mid_rst_flags", 64'({bus.busy, bus.done, bus.dbz, bus.illegal_op}), 64'd0);
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) done_seen = 1'b1;
        end
        check("mid_rst_no_done", 64'(done_seen), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
